// File: rtl/mul_div_if.sv
// ----------------------------------------------------------------------------
// mul_div_if -- execute-stage handshake bundle for mul_div_unit. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mul_div_if #(
  parameter int XLEN = 32
);
  logic [3:0]      mulDiv_op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            start;
  logic            kill;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output mulDiv_op, rs1, rs2, start, kill,
    input  stall, busy, done, result
  );

  modport slave (
    input  mulDiv_op, rs1, rs2, start, kill,
    output stall, busy, done, result
  );
endinterface

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ----------------------------------------------------------------------------
// mul_div_unit -- iterative RV32M multiply/divide unit (shift-add / restoring).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mul_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  mul_div_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_op;
  logic [2*XLEN-1:0]  r_acc;
  logic [XLEN-1:0]    r_b;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_busy;
  logic [XLEN-1:0]    r_result;

  logic               w_op_valid;
  logic               w_is_div;
  logic               w_neg_a;
  logic               w_neg_b;
  logic               w_div_zero;
  logic               w_overflow;
  logic               w_early;
  logic               w_accept;
  logic               w_stall;
  logic [XLEN-1:0]    w_mag_a;
  logic [XLEN-1:0]    w_mag_b;
  logic [XLEN-1:0]    w_special;
  logic [XLEN:0]      w_sum;
  logic [XLEN:0]      w_rem_sh;
  logic [XLEN:0]      w_diff;
  logic               w_ge;
  logic [2*XLEN-1:0]  w_acc_next;
  logic [2*XLEN-1:0]  w_prod_s;
  logic [XLEN-1:0]    w_quot_s;
  logic [XLEN-1:0]    w_rem_s;
  logic [XLEN-1:0]    w_final;

  localparam logic [XLEN-1:0] C_MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] C_ONES    = {XLEN{1'b1}};

  // Decoder contract: op[3] selects divide, op[2] remainder, op[1] unsigned.
  always_comb begin
    w_op_valid = 1'b0;
    case (bus.mulDiv_op)
      4'b0011, 4'b0101, 4'b0110, 4'b0111,
      4'b1001, 4'b1011, 4'b1101, 4'b1111: w_op_valid = 1'b1;
      default:                             w_op_valid = 1'b0;
    endcase
  end

  assign w_is_div   = bus.mulDiv_op[3];
  assign w_neg_a    = bus.rs1[XLEN-1] & ((bus.mulDiv_op == 4'b0101) | (bus.mulDiv_op == 4'b0110) |
                                         (bus.mulDiv_op == 4'b1001) | (bus.mulDiv_op == 4'b1101));
  assign w_neg_b    = bus.rs2[XLEN-1] & ((bus.mulDiv_op == 4'b0101) | (bus.mulDiv_op == 4'b1001) |
                                         (bus.mulDiv_op == 4'b1101));
  assign w_mag_a    = w_neg_a ? -bus.rs1 : bus.rs1;
  assign w_mag_b    = w_neg_b ? -bus.rs2 : bus.rs2;
  assign w_div_zero = w_is_div & (bus.rs2 == '0);
  assign w_overflow = w_is_div & ~bus.mulDiv_op[1] & (bus.rs1 == C_MIN_INT) & (bus.rs2 == C_ONES);
  assign w_early    = w_div_zero | w_overflow;
  assign w_accept   = (r_state == S_IDLE) & bus.start & w_op_valid & ~bus.kill;
  assign w_special  = w_div_zero ? (bus.mulDiv_op[2] ? bus.rs1 : C_ONES)
                                 : (bus.mulDiv_op[2] ? '0 : C_MIN_INT);

  // Shared iteration step: shift-add multiply or restoring divide.
  assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
  assign w_diff     = w_rem_sh - {1'b0, r_b};
  assign w_ge       = ~w_diff[XLEN];
  assign w_acc_next = r_op[3]
                    ? {(w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_ge}
                    : {w_sum, r_acc[XLEN-1:1]};

  assign w_prod_s = r_neg_q ? -w_acc_next : w_acc_next;
  assign w_quot_s = r_neg_q ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
  assign w_rem_s  = r_neg_r ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];
  assign w_final  = r_op[3] ? (r_op[2] ? w_rem_s : w_quot_s)
                            : ((r_op == 4'b0011) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN]);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = w_accept;
        if (w_accept) w_next_state = w_early ? S_DONE : S_CALC;
      end
      S_CALC: begin
        w_stall = 1'b1;
        if (r_cnt == {CNT_W{1'b1}}) w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    if (bus.kill) w_next_state = S_IDLE;
    if (!rst_n)   w_stall      = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_result <= '0;
    end else begin
      r_busy <= (w_next_state == S_CALC);
      if (w_accept) begin
        r_op    <= bus.mulDiv_op;
        r_acc   <= {{XLEN{1'b0}}, w_mag_a};
        r_b     <= w_mag_b;
        r_neg_q <= w_neg_a ^ w_neg_b;
        r_neg_r <= w_neg_a;
        r_cnt   <= '0;
        if (w_early) r_result <= w_special;
      end else if ((r_state == S_CALC) && !bus.kill) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == {CNT_W{1'b1}}) r_result <= w_final;
      end
    end
  end

  assign bus.stall  = w_stall;
  assign bus.busy   = r_busy;
  assign bus.done   = (r_state == S_DONE);
  assign bus.result = r_result;

endmodule

`default_nettype wire

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Consumes the 4-bit mulDiv_op code from the instruction decoder, plus both register operands.
- Holds the execute stage via stall until the result is ready, then returns one registered 32-bit result with a single-cycle done pulse.
- A shift-add multiplier and a restoring divider share one 32-iteration datapath. Divide-by-zero and signed overflow are resolved early.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- mulDiv_op  input  4  operation code from decoder; 0000 = none
- rs1  input  32  operand A (multiplicand/dividend)
- rs2  input  32  operand B (multiplier/divisor)
- start  input  1  execute stage presents a valid M instruction
- kill  input  1  flush (exception/branch); abort current operation
- stall  output  1  hold pipeline; combinational
- busy  output  1  operation in flight (registered)
- done  output  1  result valid, exactly one cycle
- result  output  32  registered result, held until the next done

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n).
- Reset values: state=IDLE, busy=0, done=0, result=0, counter=0. stall=0 while rst_n=0.
- Op encoding [3:0] (fixed decoder contract):
  - MUL 0011, MULH 0101, MULHSU 0110, MULHU 0111
  - DIV 1001, DIVU 1011, REM 1101, REMU 1111
  - Any other code is invalid: start is ignored, no stall.
- Signedness:
  - MULH/DIV/REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - MUL: sign-agnostic (low word).
- Datapath: magnitudes are latched on accept. The unsigned core runs, then the result is conditionally two's-complement negated when loading result.
  - Product sign = signA^signB.
  - Quotient sign = signA^signB.
  - Remainder sign = signA.
- Results:
  - MUL = product[31:0]; MULH* = product[63:32].
  - DIV* = quotient; REM* = remainder.
- States: IDLE, CALC, DONE.
- IDLE:
  - If start & valid op & ~kill: latch op, operands and signs. busy<=1.
  - If divisor==0 or (signed div/rem & rs1==0x80000000 & rs2==0xFFFFFFFF): go to DONE directly.
  - Otherwise go to CALC with counter=0.
  - stall = start & valid op & ~kill (combinational) in this cycle.
- CALC:
  - One iteration per cycle, counter increments.
  - After the counter==31 iteration, load result and go to DONE.
  - stall=1 throughout.
- DONE:
  - done=1, busy=0, stall=0; the pipeline advances this cycle.
  - start is ignored in DONE; state returns to IDLE next cycle.
- Latency: start accepted in cycle N.
  - Normal ops: CALC cycles N+1..N+32, done in N+33.
  - Early cases: done in N+1.
- Special results:
  - DIV/DIVU by 0 -> 0xFFFFFFFF; REM/REMU by 0 -> rs1.
  - Signed overflow: DIV -> 0x80000000, REM -> 0.
- kill:
  - In any state, the next state is IDLE, busy<=0, and no done is produced.
  - result keeps its old value.
  - kill in the same cycle as start in IDLE: kill wins, nothing is accepted.
  - kill in DONE: done is still high that cycle (already registered); state -> IDLE.
- Operand changes after accept have no effect; the latched copies are used.
- Reset mid-operation: all state returns to reset values on the next edge; no done.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD, start in cycle N -> stall high N..N+32, done only in N+33, result=0xFFFFFFEB.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF.
- MULH 0x80000000*0x80000000 -> 0x40000000.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU rs1=0x1234, rs2=0 -> done in N+1, result 0xFFFFFFFF. REM same operands -> 0x1234.
- DIV 0x80000000/0xFFFFFFFF -> done in N+1, result 0x80000000. REM same operands -> 0.
- kill at N+10 during MUL -> IDLE at N+11, no done through N+40, result unchanged.
- start with op 0001 or 0000 -> stall=0, busy=0.
- Back-to-back ops: second start presented in the cycle after DONE is accepted with correct latency; start held high during DONE does not retrigger.
- rst_n=0 at N+5 during DIV -> outputs at reset values next cycle.
